// File: rtl/vectored_int_ctrl_pkg.sv
// Shared types for the vectored interrupt controller: FSM state encoding and ID width helper.
package vectored_int_pkg;

    typedef enum logic [1:0] {
        VI_IDLE = 2'd0,
        VI_REQ  = 2'd1,
        VI_BUSY = 2'd2
    } vi_state_e;

    function automatic int vi_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vectored_int_ctrl_if.sv
// Bus bundle between accelerator done lines / CPU and the vectored interrupt controller.
interface vectored_int_ctrl_if #(
    parameter int NUM_SRC = 4
);
    localparam int IDW = vectored_int_pkg::vi_idw(NUM_SRC);

    logic [NUM_SRC-1:0] done;
    logic [NUM_SRC-1:0] mask;
    logic               int_ack;
    logic               eoi;
    logic               int_req;
    logic [31:0]        int_addr;
    logic [IDW-1:0]     int_id;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    modport slave (
        input  done, mask, int_ack, eoi,
        output int_req, int_addr, int_id, in_service, pending, overrun
    );

    modport master (
        output done, mask, int_ack, eoi,
        input  int_req, int_addr, int_id, in_service, pending, overrun
    );

endinterface

// File: rtl/vectored_int_ctrl_arbiter.sv
// Combinational winner select over the eligible set; one-hot grant plus encoded ID.
// VECTORED_INT_RR_EN selects round-robin from i_ptr+1, otherwise lowest index wins.
module vec_int_arbiter
    import vectored_int_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int IDW     = vi_idw(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_elig,
`ifdef VECTORED_INT_RR_EN
    input  logic [IDW-1:0]     i_ptr,
`endif
    output logic [NUM_SRC-1:0] o_gnt,
    output logic [IDW-1:0]     o_id
);

`ifdef VECTORED_INT_RR_EN
    logic w_found;
    int   w_idx;

    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_SRC;
            if (!w_found && i_elig[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_id         = IDW'(w_idx);
            end
        end
    end
`else
    // Scan downwards so the lowest eligible index is the last, winning assignment.
    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_elig[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_id     = IDW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, mask, single request, vector on ack.
// Define VECTORED_INT_RR_EN for round-robin arbitration instead of fixed priority.
module vectored_int_ctrl
    import vectored_int_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0004,
    parameter int          STRIDE_LOG2 = 0
) (
    input  logic                clk,
    input  logic                rst,
    vectored_int_ctrl_if.slave  bus
);
    localparam int IDW = vi_idw(NUM_SRC);

    vi_state_e          r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_done_q, r_pending, r_overrun;
    logic [NUM_SRC-1:0] w_edge, w_elig, w_gnt, w_clr;
    logic [IDW-1:0]     w_win_id, r_id;
    logic [31:0]        r_addr;
    logic               r_in_service, r_armed;
    logic               w_grant, w_eoi_take;

    // r_armed masks the first cycle after reset so a level held through reset is not an edge.
    assign w_edge = bus.done & ~r_done_q & {NUM_SRC{r_armed}};
    assign w_elig = r_pending & ~bus.mask;
    assign w_clr  = w_grant ? w_gnt : '0;

`ifdef VECTORED_INT_RR_EN
    logic [IDW-1:0] r_ptr;

    vec_int_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt),
        .o_id   (w_win_id)
    );

    always_ff @(posedge clk) begin
        if (rst)          r_ptr <= IDW'(NUM_SRC - 1);
        else if (w_grant) r_ptr <= w_win_id;
    end
`else
    vec_int_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .i_elig (w_elig),
        .o_gnt  (w_gnt),
        .o_id   (w_win_id)
    );
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_eoi_take  = 1'b0;
        case (r_state)
            VI_IDLE: if (|w_elig) w_state_nxt = VI_REQ;
            VI_REQ: begin
                if (!(|w_elig)) begin
                    w_state_nxt = VI_IDLE;
                end else if (bus.int_ack) begin
                    w_grant     = 1'b1;
                    w_state_nxt = VI_BUSY;
                end
            end
            VI_BUSY: begin
                if (bus.eoi) begin
                    w_eoi_take  = 1'b1;
                    w_state_nxt = (|w_elig) ? VI_REQ : VI_IDLE;
                end
            end
            default: w_state_nxt = VI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= VI_IDLE;
            r_done_q     <= '0;
            r_armed      <= 1'b0;
            r_pending    <= '0;
            r_overrun    <= '0;
            r_id         <= '0;
            r_addr       <= VEC_BASE;
            r_in_service <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done_q  <= bus.done;
            r_armed   <= 1'b1;
            // A new edge on the granted source re-pends it, but the grant still wipes its overrun.
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_overrun <= (r_overrun | (w_edge & r_pending)) & ~w_clr;
            if (w_grant) begin
                r_id         <= w_win_id;
                r_addr       <= VEC_BASE + (32'(w_win_id) << STRIDE_LOG2);
                r_in_service <= 1'b1;
            end else if (w_eoi_take) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign bus.int_req    = (r_state == VI_REQ);
    assign bus.int_addr   = r_addr;
    assign bus.int_id     = r_id;
    assign bus.in_service = r_in_service;
    assign bus.pending    = r_pending;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed table-driven bench for vectored_int_ctrl (NUM_SRC=4, VEC_BASE=4, STRIDE_LOG2=0).
module tb_vectored_int_ctrl;
    import vectored_int_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vectored_int_ctrl_if #(.NUM_SRC(4)) bus();

    vectored_int_ctrl #(
        .NUM_SRC     (4),
        .VEC_BASE    (32'h0000_0004),
        .STRIDE_LOG2 (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  done;
        logic [3:0]  mask;
        logic        ack;
        logic        eoi;
        logic        req;
        logic        svc;
        logic [1:0]  id;
        logic [31:0] addr;
        logic [3:0]  pend;
        logic [3:0]  ovr;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic [3:0] d, logic [3:0] m, logic a, logic e,
                                logic rq, logic sv, logic [1:0] id, logic [31:0] ad,
                                logic [3:0] pd, logic [3:0] ov);
        vec_t v;
        v.rst = r; v.done = d; v.mask = m; v.ack = a; v.eoi = e;
        v.req = rq; v.svc = sv; v.id = id; v.addr = ad; v.pend = pd; v.ovr = ov;
        return v;
    endfunction

    task automatic step(logic r, logic [3:0] d, logic [3:0] m, logic a, logic e);
        @(negedge clk);
        rst = r; bus.done = d; bus.mask = m; bus.int_ack = a; bus.eoi = e;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic rq, logic sv, logic [1:0] id, logic [31:0] ad,
                         logic [3:0] pd, logic [3:0] ov);
        n_vec++;
        if ({bus.int_req, bus.in_service, bus.int_id, bus.int_addr, bus.pending, bus.overrun}
            !== {rq, sv, id, ad, pd, ov}) begin
            n_err++;
            $display("FAIL %s: got req=%b svc=%b id=%0d addr=%h pend=%b ovr=%b, want req=%b svc=%b id=%0d addr=%h pend=%b ovr=%b",
                     name, bus.int_req, bus.in_service, bus.int_id, bus.int_addr, bus.pending,
                     bus.overrun, rq, sv, id, ad, pd, ov);
        end
    endtask

    initial begin
        rst = 1'b1; bus.done = '0; bus.mask = '0; bus.int_ack = 1'b0; bus.eoi = 1'b0;

        // single source 2
        tv.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 0, 0, 2'd0, 32'h4, 4'b0100, 4'b0000));
        tv.push_back(mk(0, 4'b0100, 4'b0000, 0, 0, 1, 0, 2'd0, 32'h4, 4'b0100, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd2, 32'h6, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd2, 32'h6, 4'b0000, 4'b0000));
        // reset so the round-robin pointer starts from NUM_SRC-1
        tv.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000));
        // 1011 together: IDs 0,1,3
        tv.push_back(mk(0, 4'b1011, 4'b0000, 0, 0, 0, 0, 2'd0, 32'h4, 4'b1011, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 2'd0, 32'h4, 4'b1011, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd0, 32'h4, 4'b1010, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 2'd0, 32'h4, 4'b1010, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd1, 32'h5, 4'b1000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 2'd1, 32'h5, 4'b1000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd3, 32'h7, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 32'h7, 4'b0000, 4'b0000));
        // stray ack / eoi while idle are ignored
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd3, 32'h7, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 32'h7, 4'b0000, 4'b0000));
        // re-fire all four: IDs 0,1,2,3
        tv.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 0, 2'd3, 32'h7, 4'b1111, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 2'd3, 32'h7, 4'b1111, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd0, 32'h4, 4'b1110, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 2'd0, 32'h4, 4'b1110, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd1, 32'h5, 4'b1100, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 2'd1, 32'h5, 4'b1100, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd2, 32'h6, 4'b1000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 2'd2, 32'h6, 4'b1000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd3, 32'h7, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 32'h7, 4'b0000, 4'b0000));
        // masked source latches but does not request; unmask, then re-mask in REQ with ack
        tv.push_back(mk(0, 4'b0001, 4'b0001, 0, 0, 0, 0, 2'd3, 32'h7, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0001, 4'b0001, 0, 0, 0, 0, 2'd3, 32'h7, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 2'd3, 32'h7, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 1, 0, 0, 0, 2'd3, 32'h7, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 0, 0, 2'd3, 32'h7, 4'b0001, 4'b0000));
        // overrun on source 1, cleared by its grant; ack in BUSY ignored
        tv.push_back(mk(0, 4'b0010, 4'b0001, 0, 0, 0, 0, 2'd3, 32'h7, 4'b0011, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 0, 0, 1, 0, 2'd3, 32'h7, 4'b0011, 4'b0000));
        tv.push_back(mk(0, 4'b0010, 4'b0001, 0, 0, 1, 0, 2'd3, 32'h7, 4'b0011, 4'b0010));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 1, 0, 0, 1, 2'd1, 32'h5, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 1, 0, 0, 1, 2'd1, 32'h5, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0001, 0, 1, 0, 0, 2'd1, 32'h5, 4'b0001, 4'b0000));
        // grant and new edge on the same source in one cycle: pending stays, no overrun
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 2'd1, 32'h5, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0001, 4'b0000, 1, 0, 0, 1, 2'd0, 32'h4, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0001, 4'b0000, 0, 1, 1, 0, 2'd0, 32'h4, 4'b0001, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd0, 32'h4, 4'b0000, 4'b0000));
        tv.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000));

        step(1, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b0000, 4'b0000, 0, 0);
        check("reset", 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 0, 0);
        check("post_reset_idle", 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].done, tv[i].mask, tv[i].ack, tv[i].eoi);
            check($sformatf("vec%0d", i), tv[i].req, tv[i].svc, tv[i].id, tv[i].addr,
                  tv[i].pend, tv[i].ovr);
        end

        // reset while BUSY with done[3] held high across and after reset
        step(0, 4'b1000, 4'b0000, 0, 0);
        for (int c = 0; c < 6 && !bus.int_req; c++) step(0, 4'b1000, 4'b0000, 0, 0);
        check("src3_req", 1, 0, 2'd0, 32'h4, 4'b1000, 4'b0000);
        step(0, 4'b1000, 4'b0000, 1, 0);
        check("src3_busy", 0, 1, 2'd3, 32'h7, 4'b0000, 4'b0000);
        step(1, 4'b1000, 4'b0000, 0, 0);
        check("rst_in_busy", 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b1000, 4'b0000, 0, 0);
            check($sformatf("held_level_%0d", c), 0, 0, 2'd0, 32'h4, 4'b0000, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
